// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: run-control states,
// instruction width and the special instruction words.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD_DEF    = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] HALT_OPCODE_DEF = 32'hFFFF_FFFF;

    // Run-control FSM states of the fetch stage
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

endpackage : mips_pkg

// File: rtl/instr_mem.sv
// Instruction memory: synchronous write port for the loader,
// combinational read port for fetch. Contents are never reset.
module instr_mem
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Loader write, one word per clock
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : instr_mem

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, instruction memory, IF/ID
// register and the LOAD/RUN/HALTED run-control FSM.
//
// Advance semantics: in RUN, a cycle with enable=1 is one fetch step.
// Within that step flush beats stall, and stall beats a normal advance.
// With enable=0 nothing moves, whatever stall/flush say.
module if_stage
    import mips_pkg::*;
#(
    parameter int unsigned        IMEM_DEPTH  = 256,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
    parameter logic [INSTR_W-1:0] NOP_WORD    = NOP_WORD_DEF,
    parameter int unsigned        AW          = $clog2(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               enable,
    input  logic               stall,
    input  logic               flush,
    input  logic [31:0]        branch_target,
    input  logic               imem_we,
    input  logic [AW-1:0]      imem_waddr,
    input  logic [INSTR_W-1:0] imem_wdata,
    output logic [31:0]        pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc_plus4,
    output logic               halted
);

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        pc4_q, pc4_d;

    logic               mem_we;
    logic [INSTR_W-1:0] fetch_word;
    logic [31:0]        pc_plus4;
    logic [31:0]        redirect_pc;

    assign pc_plus4    = pc_q + 32'd4;
    // Targets are forced word-aligned
    assign redirect_pc = branch_target & 32'hFFFF_FFFC;

    // Only the low index bits of the PC address memory; higher bits alias
    instr_mem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc_q[AW+1:2]),
        .rdata (fetch_word)
    );

    // Next-state, next-PC and IF/ID selection for the run-control FSM
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        mem_we  = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                pc_d    = 32'd0;
                instr_d = NOP_WORD;
                pc4_d   = 32'd0;
                mem_we  = imem_we;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    if (flush) begin
                        pc_d    = redirect_pc;
                        instr_d = NOP_WORD;
                        pc4_d   = 32'd0;
                    end else if (!stall) begin
                        instr_d = fetch_word;
                        pc4_d   = pc_plus4;
                        // The halt word still enters IF/ID so older work drains
                        if (fetch_word == HALT_OPCODE) begin
                            state_d = ST_HALTED;
                        end else begin
                            pc_d = pc_plus4;
                        end
                    end
                end
            end
            ST_HALTED: begin
                instr_d = NOP_WORD;
                pc4_d   = 32'd0;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State, PC and IF/ID registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            pc_q    <= 32'd0;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign pc             = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign halted         = (state_q == ST_HALTED);

endmodule : if_stage

// File: tb/tb_if_stage.sv
// Bench for if_stage: a cycle-by-cycle vector table whose expected
// outputs pass through a scoreboard queue before comparison.
module tb_if_stage;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] W0   = 32'h2008_0005;
    localparam logic [31:0] W1   = 32'h2009_0003;
    localparam logic [31:0] W2B  = 32'h012A_4020;
    localparam logic [31:0] W255 = 32'h1111_2222;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        enable;
    logic        stall;
    logic        flush;
    logic [31:0] branch_target;
    logic        imem_we;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        halted;

    int checks;
    int errors;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        en;
        logic        stall;
        logic        flush;
        logic [31:0] tgt;
        logic        we;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_h;
    } vec_t;

    vec_t vecs[$];
    logic [96:0] exp_q[$];

    if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .enable         (enable),
        .stall          (stall),
        .flush          (flush),
        .branch_target  (branch_target),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .halted         (halted)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic s, input logic e,
                       input logic st, input logic f, input logic [31:0] t,
                       input logic w, input logic [7:0] wa, input logic [31:0] wd,
                       input logic [31:0] epc, input logic [31:0] ei,
                       input logic [31:0] ep4, input logic eh);
        vec_t v;
        v.rst_n = r;  v.start = s;  v.en = e;  v.stall = st; v.flush = f;
        v.tgt = t;    v.we = w;     v.waddr = wa; v.wdata = wd;
        v.e_pc = epc; v.e_instr = ei; v.e_pc4 = ep4; v.e_h = eh;
        vecs.push_back(v);
    endtask

    // Drive one cycle, queue its expectation, compare after the edge
    task automatic apply(input int idx, input vec_t v);
        logic [96:0] exp_v;
        logic [96:0] got_v;
        rst_n         = v.rst_n;
        start         = v.start;
        enable        = v.en;
        stall         = v.stall;
        flush         = v.flush;
        branch_target = v.tgt;
        imem_we       = v.we;
        imem_waddr    = v.waddr;
        imem_wdata    = v.wdata;
        exp_q.push_back({v.e_pc, v.e_instr, v.e_pc4, v.e_h});
        @(posedge clk);
        #1;
        got_v = {pc, if_id_instr, if_id_pc_plus4, halted};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL vec%0d: got pc=%h instr=%h pc4=%h halted=%b, want pc=%h instr=%h pc4=%h halted=%b",
                     idx, got_v[96:65], got_v[64:33], got_v[32:1], got_v[0],
                     exp_v[96:65], exp_v[64:33], exp_v[32:1], exp_v[0]);
        end
    endtask

    initial begin
        logic [31:0] junk;
        checks = 0;
        errors = 0;
        rst_n = 1'b0; start = 1'b0; enable = 1'b0; stall = 1'b0; flush = 1'b0;
        branch_target = 32'd0; imem_we = 1'b0; imem_waddr = 8'd0; imem_wdata = 32'd0;
        junk = $urandom_range(32'h7FFF_FFFF, 1);

        //   rst s  en st fl tgt            we wa     wdata      | pc           instr  pc4          h
        // Reset state, inputs ignored under reset
        add(0, 0, 0, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd0,        NOP,  32'd0,        0);
        add(0, 1, 1, 0, 1, 32'd0,         0, 8'd0,   32'd0,      32'd0,        NOP,  32'd0,        0);
        // Load program; last write coincides with start
        add(1, 0, 0, 0, 0, 32'd0,         1, 8'd0,   W0,         32'd0,        NOP,  32'd0,        0);
        add(1, 0, 1, 0, 1, 32'd0,         1, 8'd1,   W1,         32'd0,        NOP,  32'd0,        0);
        add(1, 0, 0, 0, 0, 32'd0,         1, 8'd2,   HALT,       32'd0,        NOP,  32'd0,        0);
        add(1, 1, 0, 0, 0, 32'd0,         1, 8'd255, W255,       32'd0,        NOP,  32'd0,        0);
        // Free run to halt
        add(1, 0, 1, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd4,        W0,   32'd4,        0);
        add(1, 0, 1, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd8,        W1,   32'd8,        0);
        add(1, 0, 1, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd8,        HALT, 32'd12,       1);
        // HALTED ignores everything, including a loader write
        add(1, 1, 1, 1, 1, 32'h40,        1, 8'd0,   junk,       32'd8,        NOP,  32'd0,        1);
        add(1, 0, 0, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd8,        NOP,  32'd0,        1);
        // Reset out of HALTED, restart: word 0 must still be there
        add(0, 1, 1, 0, 1, 32'h40,        0, 8'd0,   32'd0,      32'd0,        NOP,  32'd0,        0);
        add(1, 1, 0, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd0,        NOP,  32'd0,        0);
        add(1, 0, 1, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd4,        W0,   32'd4,        0);
        // Two-cycle stall at pc=4, then resume
        add(1, 0, 1, 1, 0, 32'd0,         0, 8'd0,   32'd0,      32'd4,        W0,   32'd4,        0);
        add(1, 0, 1, 1, 0, 32'd0,         0, 8'd0,   32'd0,      32'd4,        W0,   32'd4,        0);
        add(1, 0, 1, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd8,        W1,   32'd8,        0);
        // Halt word under stall, then under flush: no halt
        add(1, 0, 1, 1, 0, 32'd0,         0, 8'd0,   32'd0,      32'd8,        W1,   32'd8,        0);
        add(1, 0, 1, 0, 1, 32'd0,         0, 8'd0,   32'd0,      32'd0,        NOP,  32'd0,        0);
        // Flush wins over stall; target low bits dropped
        add(1, 0, 1, 1, 1, 32'h13,        0, 8'd0,   32'd0,      32'h10,       NOP,  32'd0,        0);
        // enable low freezes despite flush/stall
        add(1, 0, 0, 1, 1, 32'h80,        0, 8'd0,   32'd0,      32'h10,       NOP,  32'd0,        0);
        // PC+4 wraps past the top of the address space
        add(1, 0, 1, 0, 1, 32'hFFFF_FFFF, 0, 8'd0,   32'd0,      32'hFFFF_FFFC, NOP, 32'd0,        0);
        add(1, 0, 1, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd0,        W255, 32'd0,        0);
        // Upper PC bits alias onto word 0
        add(1, 0, 1, 0, 1, 32'h400,       0, 8'd0,   32'd0,      32'h400,      NOP,  32'd0,        0);
        add(1, 0, 1, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'h404,      W0,   32'h404,      0);
        // Reload words 2/3 for single-step
        add(0, 0, 0, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd0,        NOP,  32'd0,        0);
        add(1, 0, 0, 0, 0, 32'd0,         1, 8'd2,   W2B,        32'd0,        NOP,  32'd0,        0);
        add(1, 1, 0, 0, 0, 32'd0,         1, 8'd3,   HALT,       32'd0,        NOP,  32'd0,        0);
        // Single-step with gaps; a write during RUN must not land
        add(1, 0, 1, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd4,        W0,   32'd4,        0);
        add(1, 0, 0, 0, 0, 32'd0,         1, 8'd1,   32'hDEAD_BEEF, 32'd4,     W0,   32'd4,        0);
        add(1, 0, 0, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd4,        W0,   32'd4,        0);
        add(1, 0, 1, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd8,        W1,   32'd8,        0);
        add(1, 0, 0, 1, 1, 32'h20,        0, 8'd0,   32'd0,      32'd8,        W1,   32'd8,        0);
        add(1, 0, 1, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd12,       W2B,  32'd12,       0);
        add(1, 0, 0, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd12,       W2B,  32'd12,       0);
        add(1, 0, 1, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd12,       HALT, 32'd16,       1);
        add(1, 0, 0, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd12,       NOP,  32'd0,        1);
        add(0, 0, 0, 0, 0, 32'd0,         0, 8'd0,   32'd0,      32'd0,        NOP,  32'd0,        0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_if_stage
